// File: rtl/div_pkg.sv
// Shared types and constants for the round-robin divide scheduler.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 4;

   typedef logic req_id_t;

   // With both requesters valid the pointer decides; otherwise the lone valid one wins.
   function automatic req_id_t rr_pick(input logic [1:0] valid, input req_id_t ptr);
      if (valid == 2'b11) return ptr;
      return valid[1];
   endfunction

endpackage

// File: rtl/div_sched_if.sv
// Request/response bundle between two requesters and the divide scheduler.
interface div_sched_if
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   // Handshake: a requester raises req_valid[i] with stable operands and keeps both
   // until req_ready[i] is seen high in the same cycle; rsp_valid is a one-cycle pulse
   // and the result fields hold until the next pulse.
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [WIDTH-1:0] a0_input;
   logic [WIDTH-1:0] b0_input;
   logic [WIDTH-1:0] a1_input;
   logic [WIDTH-1:0] b1_input;
   logic             rsp_valid;
   logic             rsp_id;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output req_valid, a0_input, b0_input, a1_input, b1_input,
      input  req_ready, rsp_valid, rsp_id, quotient, remainder, div_zero
   );

   modport slave (
      input  req_valid, a0_input, b0_input, a1_input, b1_input,
      output req_ready, rsp_valid, rsp_id, quotient, remainder, div_zero
   );
endinterface

// File: rtl/div_iter_core.sv
// One restoring shift-subtract step: shifts the next dividend bit into the partial remainder.
module div_iter_core
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] dvd,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] dvd_next
);
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   // Quotient bits enter at the LSB of the dividend register as its MSBs are consumed.
   always_comb begin
      trial = {rem, dvd[WIDTH-1]};
      diff  = trial - {1'b0, dvs};
      if (diff[WIDTH]) begin
         rem_next = trial[WIDTH-1:0];
         dvd_next = {dvd[WIDTH-2:0], 1'b0};
      end else begin
         rem_next = diff[WIDTH-1:0];
         dvd_next = {dvd[WIDTH-2:0], 1'b1};
      end
   end
endmodule

// File: rtl/div_sched.sv
// Two-requester round-robin scheduler around a bit-serial restoring divider.
// Optional feature: DIV_ZERO_TRAP_EN makes a zero divisor skip RUN and flag div_zero.
module div_sched
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic        clk,
   input  logic        rst_n,
   div_sched_if.slave  bus,
   output state_t      state_dbg
);
`ifdef DIV_ZERO_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   req_id_t          ptr, owner, gnt;
   logic [1:0]       ready_c;
   logic             accept, trap;
   logic [WIDTH-1:0] a_sel, b_sel;
   logic [WIDTH-1:0] dvd_r, dvs_r, rem_r, dvd_nxt, rem_nxt;
   logic [CW-1:0]    cnt;
   logic             rsp_valid_r, rsp_id_r, div_zero_r;
   logic [WIDTH-1:0] quot_r, rem_out_r;

   div_iter_core #(.WIDTH(WIDTH)) u_core (
      .rem      (rem_r),
      .dvd      (dvd_r),
      .dvs      (dvs_r),
      .rem_next (rem_nxt),
      .dvd_next (dvd_nxt)
   );

   always_comb begin
      gnt       = rr_pick(bus.req_valid, ptr);
      a_sel     = gnt ? bus.a1_input : bus.a0_input;
      b_sel     = gnt ? bus.b1_input : bus.b0_input;
      trap      = TRAP_EN && (b_sel == '0);
      accept    = (state == IDLE) && rst_n && (bus.req_valid != 2'b00);
      ready_c   = 2'b00;
      if (accept) ready_c = gnt ? 2'b10 : 2'b01;
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = trap ? DONE : RUN;
         RUN:     if (cnt == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= 1'b0;
         owner       <= 1'b0;
         dvd_r       <= '0;
         dvs_r       <= '0;
         rem_r       <= '0;
         cnt         <= '0;
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= 1'b0;
         quot_r      <= '0;
         rem_out_r   <= '0;
         div_zero_r  <= 1'b0;
      end else begin
         state       <= state_nxt;
         rsp_valid_r <= (state_nxt == DONE);
         case (state)
            IDLE: if (accept) begin
               owner <= gnt;
               dvd_r <= a_sel;
               dvs_r <= b_sel;
               rem_r <= '0;
               cnt   <= '0;
               if (trap) begin
                  rsp_id_r   <= gnt;
                  quot_r     <= '1;
                  rem_out_r  <= a_sel;
                  div_zero_r <= 1'b1;
               end
            end
            RUN: begin
               dvd_r <= dvd_nxt;
               rem_r <= rem_nxt;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  rsp_id_r   <= owner;
                  quot_r     <= dvd_nxt;
                  rem_out_r  <= rem_nxt;
                  div_zero_r <= 1'b0;
               end
            end
            DONE:    ptr <= ~owner;
            default: ;
         endcase
      end
   end

   assign bus.req_ready = ready_c;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_id    = rsp_id_r;
   assign bus.quotient  = quot_r;
   assign bus.remainder = rem_out_r;
   assign bus.div_zero  = div_zero_r;
   assign state_dbg     = state;
endmodule
